// File: rtl/fp_mul_seq_if.sv
// Operand and result bundle between the operand decoder, fp_mul_seq and the FPU result register.
// The master side drives start, mode and unpacked operands; the slave side returns the packed result and flags.
interface fp_mul_seq_if;
   logic        start;
   logic        mode_fp;
   logic        sign_a, sign_b;
   logic [7:0]  exp_a, exp_b;
   logic [22:0] mant_a, mant_b;
   logic        is_nan_a, is_nan_b;
   logic        is_inf_a, is_inf_b;
   logic        is_zero_a, is_zero_b;
   logic        is_denorm_a, is_denorm_b;
   logic [31:0] result;
   logic        valid;
   logic        busy;
   logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

   modport master (
      output start, mode_fp, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
             is_nan_a, is_nan_b, is_inf_a, is_inf_b, is_zero_a, is_zero_b,
             is_denorm_a, is_denorm_b,
      input  result, valid, busy,
             flag_invalid, flag_overflow, flag_underflow, flag_inexact
   );

   modport slave (
      input  start, mode_fp, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
             is_nan_a, is_nan_b, is_inf_a, is_inf_b, is_zero_a, is_zero_b,
             is_denorm_a, is_denorm_b,
      output result, valid, busy,
             flag_invalid, flag_overflow, flag_underflow, flag_inexact
   );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential half/single multiplier: shift-add mantissa product, RNE rounding, denormals flushed.
// Latency 27 cycles (special operands 1); no backpressure, start is dropped while busy.
module fp_mul_seq #(
   parameter int MUL_ITERS = 24,
   parameter int SP_BIAS   = 127,
   parameter int HP_BIAS   = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   fp_mul_seq_if.slave bus
);

   typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

   localparam logic [4:0]        LAST_ITER = 5'(MUL_ITERS - 1);
   localparam logic signed [9:0] SP_BIAS_S = 10'(SP_BIAS);
   localparam logic signed [9:0] HP_SHIFT  = 10'(SP_BIAS - HP_BIAS);

   function automatic logic [31:0] inf_word(input logic mode, input logic s);
      return mode ? {s, 31'h7F80_0000} : {16'h0000, s, 15'h7C00};
   endfunction

   function automatic logic [31:0] zero_word(input logic mode, input logic s);
      return mode ? {s, 31'h0000_0000} : {16'h0000, s, 15'h0000};
   endfunction

   function automatic logic [31:0] qnan_word(input logic mode);
      return mode ? 32'h7FC0_0000 : 32'h0000_7E00;
   endfunction

   state_t            state, state_nxt;
   logic [4:0]        iter;
   logic              mode_r, sign_r;
   logic [23:0]       mcand;
   logic [47:0]       prod;
   logic signed [9:0] exp_r;
   logic [31:0]       result_r;
   logic [3:0]        flags_r;
   logic              valid_c, busy_c;

   logic              in_sign, special, spec_inv;
   logic [31:0]       spec_res;
   logic signed [9:0] exp_sum;

   assign in_sign = bus.sign_a ^ bus.sign_b;
   assign exp_sum = $signed({2'b00, bus.exp_a}) + $signed({2'b00, bus.exp_b}) - SP_BIAS_S;

   // Special operands bypass the datapath and are resolved at accept time
   always_comb begin
      special  = 1'b1;
      spec_inv = 1'b0;
      spec_res = 32'h0;
      if (bus.is_nan_a || bus.is_nan_b) begin
         spec_res = qnan_word(bus.mode_fp);
      end else if ((bus.is_inf_a && (bus.is_zero_b || bus.is_denorm_b)) ||
                   (bus.is_inf_b && (bus.is_zero_a || bus.is_denorm_a))) begin
         spec_res = qnan_word(bus.mode_fp);
         spec_inv = 1'b1;
      end else if (bus.is_inf_a || bus.is_inf_b) begin
         spec_res = inf_word(bus.mode_fp, in_sign);
      end else if (bus.is_zero_a || bus.is_zero_b || bus.is_denorm_a || bus.is_denorm_b) begin
         spec_res = zero_word(bus.mode_fp, in_sign);
      end else begin
         special = 1'b0;
      end
   end

   // prod holds {partial product, remaining multiplier bits}; each step consumes prod[0]
   logic [24:0] mul_sum;
   assign mul_sum = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, mcand} : 25'h0);

   logic signed [9:0] exp_norm;
   assign exp_norm = exp_r + (prod[47] ? 10'sd1 : 10'sd0) - (mode_r ? 10'sd0 : HP_SHIFT);

   logic [22:0]       frac_in, frac_out;
   logic              guard, sticky, rnd_up, carry;
   logic [23:0]       frac_sum;
   logic signed [9:0] exp_rnd;
   logic              ovf, unf;
   logic [31:0]       rnd_res;
   logic [3:0]        rnd_flags;

   // After NORM the leading one sits at prod[47]
   always_comb begin
      frac_in   = prod[46:24];
      guard     = prod[23];
      sticky    = |prod[22:0];
      rnd_res   = 32'h0;
      rnd_flags = 4'h0;
      if (!mode_r) begin
         frac_in = {13'h0, prod[46:37]};
         guard   = prod[36];
         sticky  = |prod[35:0];
      end
      rnd_up   = guard & (sticky | frac_in[0]);
      frac_sum = {1'b0, frac_in} + {23'h0, rnd_up};
      carry    = mode_r ? frac_sum[23] : frac_sum[10];
      frac_out = carry ? 23'h0 : frac_sum[22:0];
      exp_rnd  = exp_r + (carry ? 10'sd1 : 10'sd0);
      ovf      = exp_rnd >= (mode_r ? 10'sd255 : 10'sd31);
      unf      = exp_rnd <= 10'sd0;
      if (ovf) begin
         rnd_res   = inf_word(mode_r, sign_r);
         rnd_flags = 4'b0101;
      end else if (unf) begin
         rnd_res   = zero_word(mode_r, sign_r);
         rnd_flags = 4'b0011;
      end else begin
         rnd_res   = mode_r ? {sign_r, exp_rnd[7:0], frac_out}
                            : {16'h0000, sign_r, exp_rnd[4:0], frac_out[9:0]};
         rnd_flags = {3'b000, guard | sticky};
      end
   end

   always_comb begin
      state_nxt = state;
      valid_c   = (state == DONE);
      busy_c    = (state != IDLE);
      case (state)
         IDLE:    if (bus.start) state_nxt = special ? DONE : MUL;
         MUL:     if (iter == LAST_ITER) state_nxt = NORM;
         NORM:    state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iter     <= 5'h0;
         mode_r   <= 1'b0;
         sign_r   <= 1'b0;
         mcand    <= 24'h0;
         prod     <= 48'h0;
         exp_r    <= 10'sd0;
         result_r <= 32'h0;
         flags_r  <= 4'h0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               mode_r  <= bus.mode_fp;
               sign_r  <= in_sign;
               mcand   <= {1'b1, bus.mant_a};
               prod    <= {24'h0, 1'b1, bus.mant_b};
               exp_r   <= exp_sum;
               iter    <= 5'h0;
               flags_r <= {spec_inv, 3'b000};
               if (special) result_r <= spec_res;
            end
            MUL: begin
               prod <= {mul_sum, prod[23:1]};
               iter <= iter + 5'h1;
            end
            NORM: begin
               if (!prod[47]) prod <= {prod[46:0], 1'b0};
               exp_r <= exp_norm;
            end
            ROUND: begin
               result_r <= rnd_res;
               flags_r  <= rnd_flags;
            end
            default: ;
         endcase
      end
   end

   assign bus.result         = result_r;
   assign bus.valid          = valid_c;
   assign bus.busy           = busy_c;
   assign bus.flag_invalid   = flags_r[3];
   assign bus.flag_overflow  = flags_r[2];
   assign bus.flag_underflow = flags_r[1];
   assign bus.flag_inexact   = flags_r[0];

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed cases plus random operands against an exact-integer reference model.
module tb_fp_mul_seq;

   typedef struct packed {
      logic        mode;
      logic        sa, sb;
      logic [7:0]  ea, eb;
      logic [22:0] ma, mb;
      logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, den_a, den_b;
   } op_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   always #5 clk = ~clk;

   fp_mul_seq_if bus();

   fp_mul_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic op_t mk_op(input logic mode, input logic sa, input logic [7:0] ea,
                                 input logic [22:0] ma, input logic sb, input logic [7:0] eb,
                                 input logic [22:0] mb);
      op_t op;
      op      = '0;
      op.mode = mode;
      op.sa   = sa;
      op.ea   = ea;
      op.ma   = ma;
      op.sb   = sb;
      op.eb   = eb;
      op.mb   = mb;
      return op;
   endfunction

   function automatic op_t rand_op();
      op_t        op;
      int         r;
      logic [7:0] cl;
      op      = '0;
      op.mode = 1'($urandom_range(0, 1));
      op.sa   = 1'($urandom_range(0, 1));
      op.sb   = 1'($urandom_range(0, 1));
      op.ma   = 23'($urandom);
      op.mb   = 23'($urandom);
      if (!op.mode) begin
         op.ma[12:0] = 13'h0;
         op.mb[12:0] = 13'h0;
      end
      r = $urandom_range(0, 3);
      if (r == 0) begin
         op.ea = 8'($urandom_range(1, 254));
         op.eb = 8'($urandom_range(1, 254));
      end else if (op.mode) begin
         op.ea = 8'($urandom_range(64, 190));
         op.eb = 8'($urandom_range(64, 190));
      end else begin
         op.ea = 8'($urandom_range(110, 140));
         op.eb = 8'($urandom_range(110, 140));
      end
      r  = $urandom_range(0, 9);
      cl = 8'h0;
      if (r < 2) cl = 8'(1 << $urandom_range(0, 7));
      if (r == 1) cl = cl | 8'(1 << $urandom_range(0, 7));
      {op.nan_a, op.nan_b, op.inf_a, op.inf_b, op.zero_a, op.zero_b, op.den_a, op.den_b} = cl;
      return op;
   endfunction

   function automatic logic is_special(input op_t op);
      return op.nan_a | op.nan_b | op.inf_a | op.inf_b |
             op.zero_a | op.zero_b | op.den_a | op.den_b;
   endfunction

   // Returns {invalid, overflow, underflow, inexact, result[31:0]}
   function automatic logic [35:0] model(input op_t op);
      logic              s, inx;
      logic [31:0]       qn, inf_w, zro_w;
      longint unsigned   prod, q, rem, half, frac;
      int                top, fb, sh, et;
      s     = op.sa ^ op.sb;
      qn    = op.mode ? 32'h7FC00000 : 32'h00007E00;
      inf_w = op.mode ? {s, 31'h7F800000} : {16'h0, s, 15'h7C00};
      zro_w = op.mode ? {s, 31'h0} : {16'h0, s, 15'h0};
      if (op.nan_a || op.nan_b) return {4'b0000, qn};
      if ((op.inf_a && (op.zero_b || op.den_b)) || (op.inf_b && (op.zero_a || op.den_a)))
         return {4'b1000, qn};
      if (op.inf_a || op.inf_b) return {4'b0000, inf_w};
      if (op.zero_a || op.zero_b || op.den_a || op.den_b) return {4'b0000, zro_w};
      prod = {40'd0, 1'b1, op.ma} * {40'd0, 1'b1, op.mb};
      top  = ((prod >> 47) != 0) ? 47 : 46;
      fb   = op.mode ? 23 : 10;
      et   = int'(op.ea) + int'(op.eb) - 127 + (top - 46) - (op.mode ? 0 : 112);
      sh   = top - fb;
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      if ((q >> (fb + 1)) != 0) begin
         q  = q >> 1;
         et = et + 1;
      end
      if (et >= (op.mode ? 255 : 31)) return {4'b0101, inf_w};
      if (et <= 0) return {4'b0011, zro_w};
      frac = q - (64'd1 << fb);
      if (op.mode) return {3'b000, inx, s, et[7:0], frac[22:0]};
      return {3'b000, inx, 16'h0, s, et[4:0], frac[9:0]};
   endfunction

   task automatic drive(input op_t op);
      bus.mode_fp     = op.mode;
      bus.sign_a      = op.sa;
      bus.sign_b      = op.sb;
      bus.exp_a       = op.ea;
      bus.exp_b       = op.eb;
      bus.mant_a      = op.ma;
      bus.mant_b      = op.mb;
      bus.is_nan_a    = op.nan_a;
      bus.is_nan_b    = op.nan_b;
      bus.is_inf_a    = op.inf_a;
      bus.is_inf_b    = op.inf_b;
      bus.is_zero_a   = op.zero_a;
      bus.is_zero_b   = op.zero_b;
      bus.is_denorm_a = op.den_a;
      bus.is_denorm_b = op.den_b;
   endtask

   // Issues one operation, scrambles inputs after accept, optionally re-pulses start mid-flight
   task automatic do_op(input op_t op, input int restart_at, output logic [31:0] res,
                        output logic [3:0] flg, output int lat);
      int busy_bad;
      busy_bad = 0;
      lat      = 0;
      res      = 32'h0;
      flg      = 4'h0;
      @(negedge clk);
      drive(op);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      drive(rand_op());
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         bus.start = (i == restart_at);
         if (!bus.busy) busy_bad++;
         if (bus.valid) begin
            lat = i;
            res = bus.result;
            flg = {bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
            break;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("valid_single", {31'h0, bus.valid}, 32'h0);
      check_eq("busy_after", {31'h0, bus.busy}, 32'h0);
      check_eq("busy_during", 32'(busy_bad), 32'h0);
   endtask

   task automatic expect_op(input string tag, input op_t op, input int restart_at,
                            input logic [31:0] exp_res, input logic [3:0] exp_flg,
                            input int exp_lat);
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      do_op(op, restart_at, res, flg, lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_res"}, res, exp_res);
      check_eq({tag, "_flags"}, {28'h0, flg}, {28'h0, exp_flg});
      check_eq({tag, "_hold"}, bus.result, exp_res);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      op_t         op;
      logic [35:0] m;
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      drive(op_t'(0));
      repeat (3) @(negedge clk);
      check_eq("rst_result", bus.result, 32'h0);
      check_eq("rst_valid", {31'h0, bus.valid}, 32'h0);
      check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("rst_flags", {28'h0, bus.flag_invalid, bus.flag_overflow,
                             bus.flag_underflow, bus.flag_inexact}, 32'h0);
      rst_n = 1'b1;

      expect_op("sp_2x3", mk_op(1, 0, 8'h80, 23'h0, 0, 8'h80, 23'h400000), 0,
                32'h40C00000, 4'b0000, 27);
      expect_op("hp_1p5sq", mk_op(0, 0, 8'h7F, 23'h400000, 0, 8'h7F, 23'h400000), 0,
                32'h00004080, 4'b0000, 27);
      op = mk_op(1, 0, 8'hFF, 23'h0, 0, 8'h00, 23'h0);
      op.inf_a  = 1'b1;
      op.zero_b = 1'b1;
      expect_op("inf_x_zero", op, 0, 32'h7FC00000, 4'b1000, 1);
      op = mk_op(1, 1, 8'hFF, 23'h0, 0, 8'h80, 23'h0);
      op.inf_a = 1'b1;
      expect_op("ninf_x_2", op, 0, 32'hFF800000, 4'b0000, 1);
      expect_op("sp_ovf", mk_op(1, 0, 8'hFE, 23'h0, 0, 8'h80, 23'h0), 0,
                32'h7F800000, 4'b0101, 27);
      expect_op("hp_ovf", mk_op(0, 0, 8'h8E, 23'h0, 0, 8'h80, 23'h0), 0,
                32'h00007C00, 4'b0101, 27);
      expect_op("sp_rnd", mk_op(1, 0, 8'h7F, 23'h000001, 0, 8'h7F, 23'h000001), 0,
                32'h3F800002, 4'b0001, 27);
      expect_op("sp_unf", mk_op(1, 0, 8'h01, 23'h0, 1, 8'h01, 23'h0), 0,
                32'h80000000, 4'b0011, 27);
      expect_op("restart_mul", mk_op(1, 0, 8'h80, 23'h0, 0, 8'h80, 23'h400000), 5,
                32'h40C00000, 4'b0000, 27);
      expect_op("restart_done", mk_op(1, 1, 8'h80, 23'h0, 0, 8'h80, 23'h400000), 27,
                32'hC0C00000, 4'b0000, 27);

      // Reset mid-multiply aborts the operation
      @(negedge clk);
      drive(mk_op(1, 0, 8'h80, 23'h0, 0, 8'h80, 23'h400000));
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("abort_valid", {31'h0, bus.valid}, 32'h0);
      check_eq("abort_result", bus.result, 32'h0);
      repeat (3) @(negedge clk);
      check_eq("abort_idle_valid", {31'h0, bus.valid}, 32'h0);
      rst_n = 1'b1;
      expect_op("post_abort", mk_op(1, 0, 8'h80, 23'h0, 0, 8'h80, 23'h400000), 0,
                32'h40C00000, 4'b0000, 27);

      for (int n = 0; n < 150; n++) begin
         op = rand_op();
         m  = model(op);
         expect_op("rand", op, 0, m[31:0], m[35:32], is_special(op) ? 1 : 27);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
